// File: rtl/id_hazard_ctrl_pkg.sv
// rtl/id_hazard_ctrl_pkg.sv - shared widths, FSM encoding and scoreboard entry layout
package id_hazard_ctrl_pkg;

  localparam int WORD_LEN          = 32;
  localparam int REG_FILE_ADDR_LEN = 4;
  localparam int SB_DEPTH          = 3;
  localparam int SB_ENTRY_W        = 3 + REG_FILE_ADDR_LEN;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic                         valid;
    logic                         wb_en;
    logic                         mem_r_en;
    logic [REG_FILE_ADDR_LEN-1:0] dest;
  } sb_entry_t;

endpackage

// File: rtl/id_hazard_ctrl_sb_match.sv
// rtl/id_hazard_ctrl_sb_match.sv - compares one source register against one scoreboard entry
module sb_match
  import id_hazard_ctrl_pkg::*;
#(
  parameter bit LOAD_ONLY = 1'b0
) (
  input  sb_entry_t                    entry,
  input  logic [REG_FILE_ADDR_LEN-1:0] src,
  output logic                         match
);

  // R0 gets no special treatment: a write to R0 still blocks a read of R0.
  assign match = entry.valid && entry.wb_en && (entry.dest == src) &&
                 (!LOAD_ONLY || entry.mem_r_en);

endmodule

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID-stage hazard/flush control; FORWARDING_EN limits checks to EXE load-use
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [REG_FILE_ADDR_LEN-1:0] src1,
  input  logic [REG_FILE_ADDR_LEN-1:0] src2,
  input  logic                         is_imm,
  input  logic                         st_or_bne,
  input  logic [REG_FILE_ADDR_LEN-1:0] id_dest,
  input  logic                         id_wb_en,
  input  logic                         id_mem_r_en,
  input  logic                         br_taken,
  input  logic                         mem_freeze,
  output logic                         hazard_detected,
  output logic                         pc_freeze,
  output logic                         ifid_freeze,
  output logic                         ifid_flush,
  output logic [1:0]                   state,
  output logic [15:0]                  stall_cnt,
  output logic [15:0]                  flush_cnt
);

`ifdef FORWARDING_EN
  localparam int N_CHK     = 1;
  localparam bit LOAD_ONLY = 1'b1;
`else
  localparam int N_CHK     = SB_DEPTH;
  localparam bit LOAD_ONLY = 1'b0;
`endif

  // sb[0] = EXE, sb[1] = MEM, sb[2] = WB
  sb_entry_t  sb [SB_DEPTH];
  hz_state_e  state_q, state_d;
  logic [N_CHK-1:0] m1, m2;
  logic src2_read, in_flush, issue;

  for (genvar g = 0; g < N_CHK; g++) begin : g_chk
    sb_match #(.LOAD_ONLY(LOAD_ONLY)) u_m1 (.entry(sb[g]), .src(src1), .match(m1[g]));
    sb_match #(.LOAD_ONLY(LOAD_ONLY)) u_m2 (.entry(sb[g]), .src(src2), .match(m2[g]));
  end

  assign src2_read = !is_imm || st_or_bne;
  assign in_flush  = (state_q == ST_FLUSH);

  // During FLUSH the ID slot holds a wrong-path instruction, so it neither stalls nor issues.
  assign hazard_detected = rst && id_valid && !in_flush && ((|m1) || (src2_read && (|m2)));
  assign pc_freeze       = hazard_detected || mem_freeze;
  assign ifid_freeze     = hazard_detected || mem_freeze;
  assign ifid_flush      = rst && br_taken && !hazard_detected && !mem_freeze && !in_flush;
  assign issue           = id_valid && !hazard_detected && !in_flush;
  assign state           = state_q;

  always_comb begin
    state_d = state_q;
    if (!mem_freeze) begin
      if (hazard_detected)  state_d = ST_STALL;
      else if (ifid_flush)  state_d = ST_FLUSH;
      else                  state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SB_DEPTH; i++) sb[i] <= '0;
    end else if (!mem_freeze) begin
      sb[2] <= sb[1];
      sb[1] <= sb[0];
      if (issue) sb[0] <= '{valid: id_valid, wb_en: id_wb_en, mem_r_en: id_mem_r_en, dest: id_dest};
      else       sb[0] <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!mem_freeze && hazard_detected && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (ifid_flush && flush_cnt != 16'hFFFF)                     flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - scoreboard bench for id_hazard_ctrl, both FORWARDING_EN builds
module tb_id_hazard_ctrl;

`ifdef FORWARDING_EN
  localparam int N_ADD = 0;
  localparam int N_ST  = 0;
  localparam int N_LD  = 1;
  localparam bit FWD   = 1'b1;
`else
  localparam int N_ADD = 3;
  localparam int N_ST  = 2;
  localparam int N_LD  = 3;
  localparam bit FWD   = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic id_valid, is_imm, st_or_bne, id_wb_en, id_mem_r_en, br_taken, mem_freeze;
  logic [3:0] src1, src2, id_dest;
  logic hazard_detected, pc_freeze, ifid_freeze, ifid_flush;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  id_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .is_imm(is_imm), .st_or_bne(st_or_bne), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .br_taken(br_taken), .mem_freeze(mem_freeze),
    .hazard_detected(hazard_detected), .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze),
    .ifid_flush(ifid_flush), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hz;
    logic        pf;
    logic        fl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0]  m_st;
  logic [15:0] m_sc, m_fc;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic imm, input logic sb, input logic [3:0] d,
                        input logic wb, input logic mr, input logic br);
    id_valid = v; src1 = s1; src2 = s2; is_imm = imm; st_or_bne = sb;
    id_dest = d; id_wb_en = wb; id_mem_r_en = mr; br_taken = br;
  endtask

  task automatic compare_head(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 16'd0, 16'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq({tag, "_hazard"}, {15'd0, hazard_detected}, {15'd0, e.hz});
    check_eq({tag, "_pc_freeze"}, {15'd0, pc_freeze}, {15'd0, e.pf});
    check_eq({tag, "_ifid_freeze"}, {15'd0, ifid_freeze}, {15'd0, e.pf});
    check_eq({tag, "_flush"}, {15'd0, ifid_flush}, {15'd0, e.fl});
    check_eq({tag, "_state"}, {14'd0, state}, {14'd0, e.st});
    check_eq({tag, "_stall_cnt"}, stall_cnt, e.sc);
    check_eq({tag, "_flush_cnt"}, flush_cnt, e.fc);
  endtask

  // One clock: inputs already driven; push expectation, sample, then advance the model.
  task automatic cyc(input string tag, input logic ehz, input logic efl);
    exp_q.push_back('{hz: ehz, pf: ehz | mem_freeze, fl: efl, st: m_st, sc: m_sc, fc: m_fc});
    #1;
    compare_head(tag);
    @(posedge clk);
    if (!mem_freeze) begin
      m_st = ehz ? 2'd1 : (efl ? 2'd2 : 2'd0);
      if (ehz) m_sc = m_sc + 16'd1;
      if (efl) m_fc = m_fc + 16'd1;
    end
    #2;
  endtask

  task automatic check_reset(input string tag);
    m_st = 2'd0; m_sc = 16'd0; m_fc = 16'd0;
    exp_q.push_back('{hz: 1'b0, pf: mem_freeze, fl: 1'b0, st: 2'd0, sc: 16'd0, fc: 16'd0});
    #1;
    compare_head(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mem_freeze = 1'b0;
    m_st = 2'd0; m_sc = 16'd0; m_fc = 16'd0;
    set_id(1, 0, 0, 0, 1, 0, 1, 1, 1);
    repeat (2) @(posedge clk);
    #2;
    check_reset("rst_idle");
    mem_freeze = 1'b1;
    check_reset("rst_memfreeze");
    mem_freeze = 1'b0;
    set_id(0, 0, 0, 1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #2;

    // ALU producer R5, consumer reads it through src2
    set_id(1, 0, 0, 1, 0, 5, 1, 0, 0);  cyc("add_r5", 0, 0);
    set_id(1, 1, 5, 0, 0, 6, 1, 0, 0);
    for (int i = 0; i < N_ADD; i++) cyc("add_use", 1, 0);
    cyc("add_issue", 0, 0);
    if (!FWD) check_eq("add_stall_total", stall_cnt, 16'd3);

    // src2 ignored for immediates, read again when st_or_bne
    set_id(1, 0, 6, 1, 0, 0, 0, 0, 0);  cyc("imm_nouse", 0, 0);
    set_id(1, 0, 6, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < N_ST; i++) cyc("st_use", 1, 0);
    cyc("st_issue", 0, 0);

    // load-use on src1
    set_id(1, 0, 0, 1, 0, 3, 1, 1, 0);  cyc("ldw_r3", 0, 0);
    set_id(1, 3, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < N_LD; i++) cyc("ld_use", 1, 0);
    cyc("ld_issue", 0, 0);

    // taken branch, then a wrong-path load to R7 that must not enter EXE
    set_id(1, 0, 0, 1, 0, 0, 0, 0, 1);  cyc("br_flush", 0, 1);
    set_id(1, 0, 0, 1, 0, 7, 1, 1, 1);  cyc("in_flush", 0, 0);
    set_id(1, 7, 0, 1, 0, 0, 0, 0, 0);  cyc("post_flush", 0, 0);

    // branch deferred behind a load-use stall
    set_id(1, 0, 0, 1, 0, 3, 1, 1, 0);  cyc("ldw_r3_b", 0, 0);
    set_id(1, 3, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < N_LD; i++) cyc("br_stalled", 1, 0);
    cyc("br_late_flush", 0, 1);
    set_id(1, 0, 0, 1, 0, 0, 0, 0, 0);  cyc("br_late_flushst", 0, 0);
    cyc("br_done", 0, 0);

    // load to R0 (no exemption), stall, freeze for 4 cycles, reset mid-stall
    set_id(1, 0, 0, 1, 0, 0, 1, 1, 0);  cyc("ldw_r0", 0, 0);
    set_id(1, 0, 0, 1, 0, 0, 0, 0, 0);  cyc("r0_use", 1, 0);
    mem_freeze = 1'b1;
    for (int i = 0; i < 4; i++) cyc("frozen", !FWD, 0);
    mem_freeze = 1'b0;
    rst = 1'b0;
    check_reset("rst_midstall");
    @(posedge clk); #2;
    rst = 1'b1;
    cyc("after_rst", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
